data_demux: RTL and testbench

Receive-side time-division demultiplexer for the multiplexed data path. It takes the single byte stream produced by the data multiplexer, where each of up to three streams occupies a slot of `switch_clk_cycles` clocks in turn, and splits it back into per-stream registered outputs with one-cycle valid strobes. It recovers frame alignment from a frame-start marker. It also checks that each slot's byte is held steady for the whole slot.

---
 rtl/data_demux_pkg.sv | 23 ++
 rtl/data_demux_slot_counter.sv | 142 ++++++++++++++
 rtl/data_demux.sv | 114 +++++++++++
 tb/tb_data_demux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_demux_pkg.sv
// Shared definitions for the receive-side TDM demultiplexer.
// Holds the slot-timing state enum, width constants and the config check
// used when mode / slot length are latched at a frame boundary.
package data_demux_pkg;

    localparam int MAX_STREAMS = 3;
    localparam int MODE_W      = 2;
    localparam int DATA_W      = 8;
    localparam int CNT_W       = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A configuration is usable only with at least one stream and a
    // non-zero slot length.
    function automatic logic cfg_valid(input logic [MODE_W-1:0] mode,
                                       input logic [CNT_W-1:0]  k);
        return (mode != '0) && (k != '0);
    endfunction

endpackage

// File: rtl/data_demux_slot_counter.sv
// tdm_slot_counter: slot/frame timing for a time-division multiplexed path.
// Owns the cycle-in-slot counter (cyc, 1..K), the stream index (idx, 0..M-1)
// and the latched M/K. Config is sampled on frame_start or at the frame wrap.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame_start         first cycle of stream-1's slot
//   mode                requested number of streams (M)
//   switch_clk_cycles   requested slot length (K)
//   capture             this cycle is cycle 1 of slot idx
//   check               this cycle is cycle 2..K of slot idx
//   idx                 stream index of the current cycle
//   locked              high while in RUN
//   sync_err            1-cycle pulse after an unexpected frame_start
//   cfg_err             1-cycle pulse after an invalid config was latched
module tdm_slot_counter
    import data_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [MODE_W-1:0] mode,
    input  logic [CNT_W-1:0]  switch_clk_cycles,
    output logic              capture,
    output logic              check,
    output logic [MODE_W-1:0] idx,
    output logic              locked,
    output logic              sync_err,
    output logic              cfg_err
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cyc_reg, cyc_next, k_reg, k_next;
    logic [MODE_W-1:0] idx_reg, idx_next, m_reg, m_next;
    logic              sync_err_reg, sync_err_next;
    logic              cfg_err_reg, cfg_err_next;

    // Position and config that apply to the current cycle. A frame_start
    // forces slot 0 / cycle 1 with the freshly sampled config.
    logic              active;
    logic [CNT_W-1:0]  cyc_cur, k_cur;
    logic [MODE_W-1:0] idx_cur, m_cur;
    logic              wrap;
    logic              in_cfg_ok;

    assign in_cfg_ok = cfg_valid(mode, switch_clk_cycles);

    always_comb begin
        active  = 1'b0;
        cyc_cur = cyc_reg;
        idx_cur = idx_reg;
        m_cur   = m_reg;
        k_cur   = k_reg;
        if (frame_start) begin
            cyc_cur = CNT_W'(1);
            idx_cur = '0;
            m_cur   = mode;
            k_cur   = switch_clk_cycles;
            active  = in_cfg_ok;
        end else if (state_reg == RUN) begin
            active = 1'b1;
        end
    end

    assign wrap = active && (idx_cur == m_cur - MODE_W'(1)) && (cyc_cur == k_cur);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cyc_reg      <= CNT_W'(1);
            idx_reg      <= '0;
            m_reg        <= '0;
            k_reg        <= '0;
            sync_err_reg <= 1'b0;
            cfg_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cyc_reg      <= cyc_next;
            idx_reg      <= idx_next;
            m_reg        <= m_next;
            k_reg        <= k_next;
            sync_err_reg <= sync_err_next;
            cfg_err_reg  <= cfg_err_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        cyc_next     = cyc_reg;
        idx_next     = idx_reg;
        m_next       = m_reg;
        k_next       = k_reg;
        cfg_err_next = 1'b0;
        // In RUN the registers read slot 0 / cycle 1 only right after a wrap,
        // which is the one place a frame_start is expected.
        sync_err_next = frame_start && (state_reg == RUN) &&
                        !((cyc_reg == CNT_W'(1)) && (idx_reg == '0));

        if (frame_start) begin
            m_next = mode;
            k_next = switch_clk_cycles;
            if (!in_cfg_ok) begin
                state_next   = IDLE;
                cyc_next     = CNT_W'(1);
                idx_next     = '0;
                cfg_err_next = 1'b1;
            end
        end

        if (active) begin
            state_next = RUN;
            if (cyc_cur < k_cur) begin
                cyc_next = cyc_cur + CNT_W'(1);
                idx_next = idx_cur;
            end else if (wrap) begin
                cyc_next = CNT_W'(1);
                idx_next = '0;
                m_next   = mode;
                k_next   = switch_clk_cycles;
                if (!in_cfg_ok) begin
                    state_next   = IDLE;
                    cfg_err_next = 1'b1;
                end
            end else begin
                cyc_next = CNT_W'(1);
                idx_next = idx_cur + MODE_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        capture  = active && (cyc_cur == CNT_W'(1));
        check    = active && (cyc_cur != CNT_W'(1));
        idx      = idx_cur;
        locked   = (state_reg == RUN);
        sync_err = sync_err_reg;
        cfg_err  = cfg_err_reg;
    end

endmodule

// File: rtl/data_demux.sv
// data_demux: splits a TDM byte stream (up to three streams, K clocks per
// slot) into per-stream registered bytes with one-cycle valid strobes, and
// flags bytes that are not held steady across their slot.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   frame_start             first cycle of stream-1's slot
//   mode                    number of active streams (1..3)
//   switch_clk_cycles       slot length K (1..7)
//   mux_data                multiplexed byte stream
//   err_clr                 clears hold_err
//   ds1/ds2/ds3_data        recovered stream bytes
//   ds_valid                per-stream capture strobe, bit n-1 = stream n
//   locked                  high while slot timing is running
//   sync_err, cfg_err       1-cycle error pulses
//   hold_err                sticky in-slot byte change flag
module data_demux
    import data_demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [MODE_W-1:0] mode,
    input  logic [CNT_W-1:0]  switch_clk_cycles,
    input  logic [DATA_W-1:0] mux_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] ds1_data,
    output logic [DATA_W-1:0] ds2_data,
    output logic [DATA_W-1:0] ds3_data,
    output logic [2:0]        ds_valid,
    output logic              locked,
    output logic              sync_err,
    output logic              cfg_err,
    output logic              hold_err
);

    logic              capture;
    logic              check;
    logic [MODE_W-1:0] idx;

    logic [MAX_STREAMS-1:0][DATA_W-1:0] data_all;
    logic [MAX_STREAMS-1:0]             valid_all;
    logic [DATA_W-1:0]                  held;
    logic                               hold_err_reg;

    tdm_slot_counter u_slot (
        .clk               (clk),
        .rst               (rst),
        .frame_start       (frame_start),
        .mode              (mode),
        .switch_clk_cycles (switch_clk_cycles),
        .capture           (capture),
        .check             (check),
        .idx               (idx),
        .locked            (locked),
        .sync_err          (sync_err),
        .cfg_err           (cfg_err)
    );

    // One output register per stream; only the stream owning the slot
    // updates, so streams at or above M keep their last value.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_STREAMS; gi++) begin : g_stream
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;
            logic              sel;

            assign sel = capture && (idx == MODE_W'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= sel;
                    if (sel) begin
                        data_reg <= mux_data;
                    end
                end
            end

            assign data_all[gi]  = data_reg;
            assign valid_all[gi] = valid_reg;
        end
    endgenerate

    // Byte captured at the start of the current slot.
    always_comb begin
        held = '0;
        for (int i = 0; i < MAX_STREAMS; i++) begin
            if (idx == MODE_W'(i)) begin
                held = data_all[i];
            end
        end
    end

    // A new mismatch wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_err_reg <= 1'b0;
        end else if (check && (mux_data != held)) begin
            hold_err_reg <= 1'b1;
        end else if (err_clr) begin
            hold_err_reg <= 1'b0;
        end
    end

    assign ds1_data = data_all[0];
    assign ds2_data = data_all[1];
    assign ds3_data = data_all[2];
    assign ds_valid = valid_all;
    assign hold_err = hold_err_reg;

endmodule

// File: tb/tb_data_demux.sv
module tb_data_demux;
    import data_demux_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic [MODE_W-1:0] mode = '0;
    logic [CNT_W-1:0]  switch_clk_cycles = '0;
    logic [DATA_W-1:0] mux_data = '0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] ds1_data, ds2_data, ds3_data;
    logic [2:0]        ds_valid;
    logic              locked, sync_err, cfg_err, hold_err;

    int checks = 0;
    int errors = 0;

    data_demux dut (
        .clk               (clk),
        .rst               (rst),
        .frame_start       (frame_start),
        .mode              (mode),
        .switch_clk_cycles (switch_clk_cycles),
        .mux_data          (mux_data),
        .err_clr           (err_clr),
        .ds1_data          (ds1_data),
        .ds2_data          (ds2_data),
        .ds3_data          (ds3_data),
        .ds_valid          (ds_valid),
        .locked            (locked),
        .sync_err          (sync_err),
        .cfg_err           (cfg_err),
        .hold_err          (hold_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame position is a single phase p in 0..M*K-1; stream = p/K,
    // cycle-in-slot = p%K.
    int         p = 0, m = 0, k = 0;
    bit         run = 0;
    logic [7:0] e_data [3] = '{8'h00, 8'h00, 8'h00};
    logic [2:0] e_valid = 3'b000;
    bit         e_sync = 0, e_cfg = 0, e_hold = 0;
    bit         mism;
    int         s, c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p = 0; m = 0; k = 0; run = 0;
            e_data[0] = 8'h00; e_data[1] = 8'h00; e_data[2] = 8'h00;
            e_valid = 3'b000; e_sync = 0; e_cfg = 0; e_hold = 0;
        end else begin
            e_valid = 3'b000; e_sync = 0; e_cfg = 0; mism = 0;
            if (frame_start) begin
                if (run && p != 0) e_sync = 1;
                m = int'(mode); k = int'(switch_clk_cycles); p = 0;
                run = (m != 0) && (k != 0);
                if (!run) e_cfg = 1;
            end
            if (run) begin
                s = p / k;
                c = p % k;
                if (c == 0) begin
                    e_data[s] = mux_data;
                    e_valid[s] = 1'b1;
                end else if (mux_data != e_data[s]) begin
                    mism = 1;
                end
                p++;
                if (p == m * k) begin
                    p = 0;
                    m = int'(mode); k = int'(switch_clk_cycles);
                    if (m == 0 || k == 0) begin
                        run = 0;
                        e_cfg = 1;
                    end
                end
            end
            e_hold = mism ? 1'b1 : (err_clr ? 1'b0 : e_hold);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        cmp("ds1_data", 32'(ds1_data), 32'(e_data[0]));
        cmp("ds2_data", 32'(ds2_data), 32'(e_data[1]));
        cmp("ds3_data", 32'(ds3_data), 32'(e_data[2]));
        cmp("ds_valid", 32'(ds_valid), 32'(e_valid));
        cmp("locked",   32'(locked),   32'(run));
        cmp("sync_err", 32'(sync_err), 32'(e_sync));
        cmp("cfg_err",  32'(cfg_err),  32'(e_cfg));
        cmp("hold_err", 32'(hold_err), 32'(e_hold));
    end

    // One cycle of stimulus; on return the outputs reflect this cycle.
    task automatic step(input logic fs, input int md, input int kk, input int d, input logic clr);
        frame_start = fs;
        mode = MODE_W'(md);
        switch_clk_cycles = CNT_W'(kk);
        mux_data = DATA_W'(d);
        err_clr = clr;
        @(posedge clk);
        #1;
        $display("t=%0t fs=%0b mode=%0d k=%0d data=%02h clr=%0b -> ds=%02h/%02h/%02h v=%03b lk=%0b se=%0b ce=%0b he=%0b",
                 $time, fs, md, kk, d, clr, ds1_data, ds2_data, ds3_data, ds_valid,
                 locked, sync_err, cfg_err, hold_err);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_ds1", 32'(ds1_data), 32'h0);
        cmp("rst_valid", 32'(ds_valid), 32'h0);
        cmp("rst_locked", 32'(locked), 32'h0);
        rst = 1'b0;
        step(0, 0, 0, 8'hFF, 0);

        // M=2, K=3: two frames, second without frame_start
        step(1, 2, 3, 8'h0A, 0);
        cmp("t1_ds1", 32'(ds1_data), 32'h0A);
        cmp("t1_v1", 32'(ds_valid), 32'b001);
        cmp("t1_locked", 32'(locked), 32'h1);
        step(0, 2, 3, 8'h0A, 0);
        step(0, 2, 3, 8'h0A, 0);
        step(0, 2, 3, 8'h0B, 0);
        cmp("t1_ds2", 32'(ds2_data), 32'h0B);
        cmp("t1_v2", 32'(ds_valid), 32'b010);
        step(0, 2, 3, 8'h0B, 0);
        step(0, 2, 3, 8'h0B, 0);
        step(0, 2, 3, 8'h1A, 0);
        cmp("t1_rep_ds1", 32'(ds1_data), 32'h1A);
        cmp("t1_rep_v", 32'(ds_valid), 32'b001);
        step(0, 2, 3, 8'h1A, 0);
        step(0, 2, 3, 8'h1A, 0);
        for (int i = 0; i < 3; i++) step(0, 2, 3, 8'h1B, 0);
        cmp("t1_rep_ds2", 32'(ds2_data), 32'h1B);

        // M=3, K=2, frame_start exactly at the wrap point
        step(1, 3, 2, 8'h11, 0);
        cmp("t2_sync", 32'(sync_err), 32'h0);
        cmp("t2_v1", 32'(ds_valid), 32'b001);
        step(0, 3, 2, 8'h11, 0);
        step(0, 3, 2, 8'h22, 0);
        cmp("t2_ds2", 32'(ds2_data), 32'h22);
        step(0, 3, 2, 8'h22, 0);
        step(0, 3, 2, 8'h33, 0);
        cmp("t2_ds3", 32'(ds3_data), 32'h33);
        cmp("t2_v3", 32'(ds_valid), 32'b100);
        step(0, 3, 2, 8'h33, 0);
        cmp("t2_hold", 32'(hold_err), 32'h0);

        // M=1, K=6: byte changes on cycle 4
        step(1, 1, 6, 8'h5A, 0);
        step(0, 1, 6, 8'h5A, 0);
        step(0, 1, 6, 8'h5A, 0);
        step(0, 1, 6, 8'h5B, 0);
        cmp("t3_hold_set", 32'(hold_err), 32'h1);
        cmp("t3_ds1", 32'(ds1_data), 32'h5A);
        step(0, 1, 6, 8'h5A, 1);
        cmp("t3_hold_clr", 32'(hold_err), 32'h0);
        step(0, 1, 6, 8'h5C, 1);
        cmp("t3_set_beats_clr", 32'(hold_err), 32'h1);

        // Unexpected frame_start at idx=1, cyc=2
        step(1, 2, 3, 8'h21, 1);
        cmp("t4_hold_clr", 32'(hold_err), 32'h0);
        step(0, 2, 3, 8'h21, 0);
        step(0, 2, 3, 8'h21, 0);
        step(0, 2, 3, 8'h31, 0);
        step(1, 2, 3, 8'h41, 0);
        cmp("t4_sync", 32'(sync_err), 32'h1);
        cmp("t4_ds1", 32'(ds1_data), 32'h41);
        cmp("t4_v1", 32'(ds_valid), 32'b001);
        step(0, 2, 3, 8'h41, 0);
        cmp("t4_sync_pulse", 32'(sync_err), 32'h0);

        // Invalid mode at frame_start, then mid-frame mode change
        step(1, 0, 3, 8'h55, 0);
        cmp("t5_cfg", 32'(cfg_err), 32'h1);
        cmp("t5_locked", 32'(locked), 32'h0);
        cmp("t5_valid", 32'(ds_valid), 32'h0);
        step(0, 0, 3, 8'h55, 0);
        cmp("t5_cfg_pulse", 32'(cfg_err), 32'h0);
        step(1, 2, 2, 8'h61, 0);
        step(0, 2, 2, 8'h61, 0);
        step(0, 3, 2, 8'h62, 0);
        step(0, 3, 2, 8'h62, 0);
        cmp("t5_ds3_kept", 32'(ds3_data), 32'h33);
        step(0, 3, 2, 8'h71, 0);
        step(0, 3, 2, 8'h71, 0);
        step(0, 3, 2, 8'h72, 0);
        step(0, 3, 2, 8'h72, 0);
        step(0, 3, 2, 8'h73, 0);
        cmp("t5_ds3_new", 32'(ds3_data), 32'h73);
        cmp("t5_v3", 32'(ds_valid), 32'b100);
        step(0, 3, 0, 8'h73, 0);
        cmp("t5_wrap_cfg", 32'(cfg_err), 32'h1);
        cmp("t5_wrap_locked", 32'(locked), 32'h0);

        // Reset during stream 2's slot
        step(1, 2, 3, 8'h81, 0);
        step(0, 2, 3, 8'h81, 0);
        step(0, 2, 3, 8'h81, 0);
        step(0, 2, 3, 8'h82, 0);
        step(0, 2, 3, 8'h82, 0);
        rst = 1'b1;
        #1;
        cmp("t6_ds1", 32'(ds1_data), 32'h0);
        cmp("t6_ds2", 32'(ds2_data), 32'h0);
        cmp("t6_locked", 32'(locked), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 2, 3, 8'h90, 0);
        cmp("t6_idle_locked", 32'(locked), 32'h0);
        cmp("t6_idle_v", 32'(ds_valid), 32'h0);
        step(1, 2, 3, 8'h91, 0);
        cmp("t6_relock", 32'(locked), 32'h1);
        cmp("t6_ds1", 32'(ds1_data), 32'h91);
        step(0, 2, 3, 8'h91, 0);
        step(0, 2, 3, 8'h91, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
